acc_seq: RTL and testbench
==========================

# acc_seq

Burst sequencer for the shared `acc` accumulator datapath. It accepts a job command with an operand count and streams the operands into the accumulator over a valid/ready handshake. It steers the accumulator's load/accumulate controls, tracks unsigned overflow and returns the final sum on a valid/ready response port. It sits between the operand producer and the accumulator instance; the accumulator itself stays a passive registered datapath.

## Interface
- DATA_WIDTH, 32: operand/sum width; matches `acc_pkg::DATA_WIDTH`.
- CNT_WIDTH, 8: width of the operand count field.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  job accepted when `cmd_valid & cmd_ready`.
- cmd_len  in  CNT_WIDTH  operands in the job, 0 to 2^CNT_WIDTH-1.
- op_valid  in  1  operand valid.
- op_ready  out  1  operand accepted when `op_valid & op_ready`.
- op_data  in  DATA_WIDTH  operand (unsigned).
- res_valid  out  1  sum available.
- res_ready  in  1  sum consumed when `res_valid & res_ready`.
- res_data  out  DATA_WIDTH  final sum, modulo 2^DATA_WIDTH.
- res_ovf  out  1  at least one carry-out occurred during the job.
- acc_a  out  DATA_WIDTH  accumulator operand A, always equal to `op_data`.
- acc_b  out  DATA_WIDTH  accumulator operand B, tied to 0.
- acc_accumulate  out  1  1 selects `y_next = a + y`; 0 selects `y_next = a + b`.
- acc_enable  out  1  accumulator register load enable.
- acc_y  in  DATA_WIDTH  accumulator registered output.

## Operation
- FSM states and outputs:
  - IDLE: `cmd_ready = 1`.
  - ACCUM: `op_ready = 1`.
  - DRAIN: no handshakes open.
  - RESP: `res_valid = 1`.
  - `cmd_ready`, `op_ready` and `res_valid` are 0 outside their own state and 0 while `rst` is high.
- Transitions:
  - IDLE, command handshake with `cmd_len != 0`: go to ACCUM. Latch `remaining = cmd_len`, set `first = 1`, clear the sticky overflow flag.
  - IDLE, command handshake with `cmd_len == 0`: go to RESP. Load `res_data = 0` and `res_ovf = 0`. The accumulator is never enabled.
  - ACCUM, operand handshake: `remaining -= 1`, `first <= 0`. If `remaining == 1` before the decrement, go to DRAIN.
  - DRAIN: exactly one cycle. Capture `res_data <= acc_y` and `res_ovf <= sticky`, then go to RESP.
  - RESP, response handshake: go to IDLE.
- Accumulator steering (combinational):
  - `acc_enable = op_valid & op_ready`.
  - `acc_accumulate = ~first`. The first operand loads `op_data + 0`; later operands add onto `acc_y`.
- Overflow:
  - Carry bit DATA_WIDTH of `{0,acc_a} + {0, first ? 0 : acc_y}`.
  - ORed into the sticky flag on every operand handshake.
- Width rules: the sum wraps modulo 2^DATA_WIDTH. `remaining` is CNT_WIDTH bits and never wraps, because it is only decremented from a nonzero value.
- Boundary conditions:
  - `op_valid` outside ACCUM is ignored and does not stall the FSM.
  - `cmd_valid` outside IDLE is not accepted. A command asserted in the same cycle as the response handshake is accepted one cycle later at the earliest.
  - Gaps in `op_valid` during ACCUM hold state; `acc_enable` stays 0 during a gap.
  - `res_data` and `res_ovf` stay stable while `res_valid & ~res_ready`.
  - Reset mid-job: immediate return to IDLE. `remaining`, `first` and the sticky flag are cleared and the pending job is dropped. Accumulator contents are don't-care, because the next job's first operand reloads them.

## Timing
- Reset values:
  - State IDLE; `res_data = 0`, `res_ovf = 0`.
  - `cmd_ready = op_ready = res_valid = acc_enable = acc_accumulate = 0` while `rst` is high.
  - `cmd_ready = 1` from the first cycle after `rst` falls.
- Command handshake at cycle c: `op_ready = 1` from c+1.
- Last operand handshake at cycle t: the accumulator updates at the end of t, DRAIN is at t+1, and `res_valid = 1` from t+2.
- With back-to-back operands, an N-operand job completes its response at c+N+2 at the earliest.
- `len == 0`: `res_valid` at c+1.
- Throughput: one operand per cycle; minimum command-to-command spacing is N+3 cycles.

## Test plan
- Reset: assert `rst` mid-cycle asynchronously -> all handshake outputs 0 immediately, `res_data = 0`. Release -> `cmd_ready = 1` next cycle.
- `cmd_len = 4`, operands 1,2,3,4 back-to-back:
  - `acc_enable` high for 4 cycles, with `acc_accumulate` = 0,1,1,1.
  - `res_valid` 2 cycles after the last operand, with `res_data = 10` and `res_ovf = 0`.
- `cmd_len = 2`, operands 0xFFFFFFFF then 0x00000002 -> `res_data = 0x00000001`, `res_ovf = 1`.
- `cmd_len = 0` -> `res_valid` 1 cycle after the command handshake, `res_data = 0`, `acc_enable` never asserted.
- Backpressure, `cmd_len = 3`, operands 5,6,7 with 2-cycle `op_valid` gaps, `res_ready` held low for 5 cycles:
  - `res_data = 18` stays stable throughout and `cmd_ready = 0`.
  - A command asserted in the handshake cycle is accepted one cycle later.
- Reset after 2 of 4 operands -> IDLE, no `res_valid`. A following job with `cmd_len = 1` and operand 7 -> `acc_accumulate = 0`, `res_data = 7`, `res_ovf = 0`.

Source files
------------

// File: rtl/acc_seq.sv
// Burst sequencer for the shared accumulator: takes a job of N operands, steers the
// accumulator load/accumulate controls, tracks unsigned overflow and returns the sum.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a job command (cmd_ready)
// ACCUM | streaming operands into the accumulator (op_ready)
// DRAIN | one cycle for the accumulator register to settle; capture sum
// RESP  | holding the result until the consumer takes it (res_valid)
module acc_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ovf,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic                  acc_accumulate,
  output logic                  acc_enable,
  input  logic [DATA_WIDTH-1:0] acc_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   remaining;
  logic                   first;
  logic                   sticky;
  logic [DATA_WIDTH:0]    sum_ext;
  logic                   carry;
  logic                   cmd_hs;
  logic                   op_hs;
  logic                   res_hs;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign op_hs  = op_valid & op_ready;
  assign res_hs = res_valid & res_ready;

  // Mirror of the accumulator adder so the carry-out is seen without widening it.
  assign sum_ext = {1'b0, acc_a} + {1'b0, (first ? {DATA_WIDTH{1'b0}} : acc_y)};
  assign carry   = sum_ext[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_hs) begin
          state_nxt = (cmd_len != '0) ? S_ACCUM : S_RESP;
        end
      end
      S_ACCUM: begin
        if (op_hs && remaining == CNT_WIDTH'(1)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_RESP;
      S_RESP: begin
        if (res_hs) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are forced low while rst is high, independent of state.
  always_comb begin
    cmd_ready      = ~rst & (state == S_IDLE);
    op_ready       = ~rst & (state == S_ACCUM);
    res_valid      = ~rst & (state == S_RESP);
    acc_enable     = op_valid & op_ready;
    acc_accumulate = ~rst & ~first;
    acc_a          = op_data;
    acc_b          = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      first     <= 1'b0;
      sticky    <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            if (cmd_len != '0) begin
              remaining <= cmd_len;
              first     <= 1'b1;
              sticky    <= 1'b0;
            end else begin
              res_data <= '0;
              res_ovf  <= 1'b0;
            end
          end
        end
        S_ACCUM: begin
          if (op_hs) begin
            remaining <= remaining - CNT_WIDTH'(1);
            first     <= 1'b0;
            sticky    <= sticky | carry;
          end
        end
        S_DRAIN: begin
          // Last operand landed in the accumulator at the end of the previous cycle.
          res_data <= acc_y;
          res_ovf  <= sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq with a behavioural accumulator attached; inputs change
// on the falling edge and outputs are checked 1 ns later, away from the rising edge.
module tb_acc_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovf;
  logic [31:0] acc_a;
  logic [31:0] acc_b;
  logic        acc_accumulate;
  logic        acc_enable;
  logic [31:0] acc_y;

  int checks   = 0;
  int failures = 0;

  acc_seq #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_len        (cmd_len),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_data        (op_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_ovf        (res_ovf),
    .acc_a          (acc_a),
    .acc_b          (acc_b),
    .acc_accumulate (acc_accumulate),
    .acc_enable     (acc_enable),
    .acc_y          (acc_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive accumulator; deliberately not reset, its contents are don't-care between jobs.
  initial acc_y = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (acc_enable) begin
      acc_y <= acc_accumulate ? (acc_a + acc_y) : (acc_a + acc_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic run_job(input logic [7:0] len, input logic [127:0] ops, input int gap,
                         input int hold, input logic [31:0] exp_sum, input logic exp_ovf,
                         input logic next_cmd);
    cmd_valid = 1'b1;
    cmd_len   = len;
    #1 check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      for (int g = 0; g < gap; g++) begin
        op_valid = 1'b0;
        #1 check("gap_acc_enable", {31'd0, acc_enable}, 32'd0);
        check("gap_op_ready", {31'd0, op_ready}, 32'd1);
        cyc();
      end
      op_valid = 1'b1;
      op_data  = ops[i*32 +: 32];
      #1 check("op_acc_enable", {31'd0, acc_enable}, 32'd1);
      check("op_acc_accumulate", {31'd0, acc_accumulate}, (i == 0) ? 32'd0 : 32'd1);
      check("op_acc_a", acc_a, ops[i*32 +: 32]);
      check("op_acc_b", acc_b, 32'd0);
      cyc();
    end
    op_valid = 1'b0;
    #1 check("drain_op_ready", {31'd0, op_ready}, 32'd0);
    check("drain_res_valid", {31'd0, res_valid}, 32'd0);
    check("drain_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cyc();
    for (int h = 0; h < hold; h++) begin
      #1 check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      check("hold_res_data", res_data, exp_sum);
      check("hold_res_ovf", {31'd0, res_ovf}, {31'd0, exp_ovf});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      cyc();
    end
    res_ready = 1'b1;
    if (next_cmd) begin
      cmd_valid = 1'b1;
      cmd_len   = 8'd0;
    end
    #1 check("resp_res_valid", {31'd0, res_valid}, 32'd1);
    check("resp_res_data", res_data, exp_sum);
    check("resp_res_ovf", {31'd0, res_ovf}, {31'd0, exp_ovf});
    check("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cyc();
    res_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    op_valid  = 1'b1;
    op_data   = 32'd9;
    res_ready = 1'b1;

    // Reset held: every handshake/steering output low, result cleared.
    cyc();
    #1 check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_acc_enable", {31'd0, acc_enable}, 32'd0);
    check("rst_acc_accumulate", {31'd0, acc_accumulate}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_ovf", {31'd0, res_ovf}, 32'd0);
    cyc();
    cmd_valid = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    rst       = 1'b0;
    cyc();
    #1 check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
    cyc();

    // 1+2+3+4 back-to-back.
    run_job(8'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 32'd10, 1'b0, 1'b0);
    #1 check("after4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("after4_res_valid", {31'd0, res_valid}, 32'd0);
    cyc();

    // Wrap and carry-out.
    run_job(8'd2, {64'd0, 32'h0000_0002, 32'hFFFF_FFFF}, 0, 0, 32'h0000_0001, 1'b1, 1'b0);

    // Zero-length job, stray op_valid must not enable the accumulator.
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    op_valid  = 1'b1;
    op_data   = 32'd99;
    #1 check("len0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("len0_acc_enable_idle", {31'd0, acc_enable}, 32'd0);
    cyc();
    cmd_valid = 1'b0;
    #1 check("len0_res_valid", {31'd0, res_valid}, 32'd1);
    check("len0_res_data", res_data, 32'd0);
    check("len0_res_ovf", {31'd0, res_ovf}, 32'd0);
    check("len0_acc_enable_resp", {31'd0, acc_enable}, 32'd0);
    check("len0_op_ready", {31'd0, op_ready}, 32'd0);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    op_valid  = 1'b0;

    // 5+6+7 with operand gaps and response backpressure; command raised in the handshake cycle.
    run_job(8'd3, {32'd0, 32'd7, 32'd6, 32'd5}, 2, 5, 32'd18, 1'b0, 1'b1);
    #1 check("late_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("late_res_valid", {31'd0, res_valid}, 32'd0);
    cyc();
    cmd_valid = 1'b0;
    #1 check("late_len0_res_valid", {31'd0, res_valid}, 32'd1);
    check("late_len0_res_data", res_data, 32'd0);
    res_data_keep: begin
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
    end

    // Set up a nonzero result so the reset clearing res_data is observable.
    run_job(8'd1, {96'd0, 32'd18}, 0, 0, 32'd18, 1'b0, 1'b0);

    // Reset partway through a 4-operand job.
    cmd_valid = 1'b1;
    cmd_len   = 8'd4;
    cyc();
    cmd_valid = 1'b0;
    op_valid  = 1'b1;
    op_data   = 32'd1;
    cyc();
    op_data   = 32'd2;
    cyc();
    op_valid  = 1'b0;
    #2 rst = 1'b1;
    #1 check("midrst_op_ready", {31'd0, op_ready}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_res_data", res_data, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    #1 check("midrst_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_idle_res_valid", {31'd0, res_valid}, 32'd0);
    cyc();
    run_job(8'd1, {96'd0, 32'd7}, 0, 0, 32'd7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
